// File: rtl/stream_padder_if.sv
// Ready/valid stream bundle for stream_padder: upstream operand words in, padded words out.
// The slave modport is the padder's view; master is the surrounding environment.
interface stream_padder_if #(
    parameter int REGISTER_SIZE = 32
);
    logic [REGISTER_SIZE-1:0] data_in;
    logic                     valid_in;
    logic                     ready_out;
    logic [REGISTER_SIZE-1:0] data_out;
    logic                     valid_out;
    logic                     ready_in;
    logic                     last_out;

    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, last_out
    );

    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, last_out
    );
endinterface

// File: rtl/stream_padder.sv
// Zero-padding stream stage: widens an IN_WORDS-word operand by a runtime number of zero
// words, either appended (zero-extension) or prepended (left shift), with a last marker.
module stream_padder #(
    parameter  int REGISTER_SIZE = 32,
    parameter  int BITS_IN_NUM   = 4096,
    parameter  int MAX_PADS      = 4096,
    localparam int IN_WORDS      = BITS_IN_NUM / REGISTER_SIZE,
    localparam int MAX_PAD_WORDS = MAX_PADS / REGISTER_SIZE,
    localparam int PAD_W         = $clog2(MAX_PAD_WORDS + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             mode_in,
    input  logic [PAD_W-1:0] pad_words_in,
    output logic             busy_out,
    stream_padder_if.slave   bus
);
    localparam int CNT_W = $clog2(((IN_WORDS > MAX_PAD_WORDS) ? IN_WORDS : MAX_PAD_WORDS) + 1);
    localparam logic [CNT_W-1:0] IN_LAST = CNT_W'(IN_WORDS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRE_PAD  = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_POST_PAD = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    logic [2:0]               state_q, state_d;
    logic                     mode_q, mode_d;
    logic [CNT_W-1:0]         pad_q, pad_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [REGISTER_SIZE-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     busy_q, busy_d;

    logic             load_en;
    logic             out_hs;
    logic             in_hs;
    logic [CNT_W-1:0] pad_clamped;
    logic [CNT_W-1:0] pad_last;

    assign load_en  = !valid_q || bus.ready_in;
    assign out_hs   = valid_q && bus.ready_in;
    assign in_hs    = bus.valid_in && bus.ready_out;
    assign pad_last = pad_q - CNT_W'(1);

    assign bus.ready_out = (state_q == S_DATA) && load_en;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
    assign busy_out      = busy_q;

    always_comb begin
        if (pad_words_in > PAD_W'(MAX_PAD_WORDS)) begin
            pad_clamped = CNT_W'(MAX_PAD_WORDS);
        end else begin
            pad_clamped = CNT_W'(pad_words_in);
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        mode_d  = mode_q;
        pad_d   = pad_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;

        // A handed-off word empties the register unless something below reloads it.
        if (out_hs) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    mode_d  = mode_in;
                    pad_d   = pad_clamped;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (mode_in && pad_clamped != '0) ? S_PRE_PAD : S_DATA;
                end
            end
            S_PRE_PAD: begin
                if (load_en) begin
                    data_d  = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    if (cnt_q == pad_last) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (in_hs) begin
                    data_d  = bus.data_in;
                    valid_d = 1'b1;
                    // The final data word is last only when no zeros follow it.
                    last_d  = (cnt_q == IN_LAST) && (mode_q || pad_q == '0);
                    if (cnt_q == IN_LAST) begin
                        cnt_d   = '0;
                        state_d = (!mode_q && pad_q != '0) ? S_POST_PAD : S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_POST_PAD: begin
                if (load_en) begin
                    data_d  = '0;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == pad_last);
                    if (cnt_q == pad_last) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_hs && last_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            pad_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pad_q   <= pad_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_stream_padder.sv
// Bench for stream_padder (8-bit words, 4-word operand, up to 8 pad words): fixed vectors,
// hand-written reset corner case, and randomized transactions against a queue-based model.
module tb_stream_padder;
    localparam int RS = 8;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       start_in = 1'b0;
    logic       mode_in = 1'b0;
    logic [3:0] pad_words_in = '0;
    logic       busy_out;

    stream_padder_if #(.REGISTER_SIZE(RS)) bus ();

    stream_padder #(
        .REGISTER_SIZE(8),
        .BITS_IN_NUM  (32),
        .MAX_PADS     (64)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (start_in),
        .mode_in     (mode_in),
        .pad_words_in(pad_words_in),
        .busy_out    (busy_out),
        .bus         (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_d[$];
    logic       got_l[$];
    int         got_c[$];
    logic [7:0] exp_q[$];
    int         acc_cyc;

    typedef struct packed {
        logic        mode;
        logic [3:0]  pad;
        logic [1:0]  rdy;   // 0: always ready, 1: 1,0,0 pattern, 2: random
        logic [3:0]  len;
        logic [95:0] exp;   // word i at bits [8*i +: 8]
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: clamp the pad count, then place zeros before or after the four data words.
    task automatic build_model(input logic mode, input logic [3:0] pad, input logic [31:0] words);
        int padc;
        padc = (int'(pad) > 8) ? 8 : int'(pad);
        exp_q.delete();
        if (mode) for (int i = 0; i < padc; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(words >> (8 * i)));
        if (!mode) for (int i = 0; i < padc; i++) exp_q.push_back(8'h00);
    endtask

    task automatic compare(input string name);
        int n;
        check($sformatf("%s_len", name), 32'(got_d.size()), 32'(exp_q.size()));
        n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", name, i), 32'(got_d[i]), 32'(exp_q[i]));
            check($sformatf("%s_last%0d", name, i), 32'(got_l[i]), 32'(i == exp_q.size() - 1));
        end
    endtask

    task automatic run_txn(input logic mode, input logic [3:0] pad, input int rdy_kind,
                           input logic [31:0] words, input bit rand_valid, input bit spur,
                           input int abort_after);
        int   idx;
        int   padc;
        bit   done;
        bit   stall_p;
        logic [7:0] d_p;
        logic l_p;
        got_d.delete();
        got_l.delete();
        got_c.delete();
        padc    = (int'(pad) > 8) ? 8 : int'(pad);
        idx     = 0;
        done    = 1'b0;
        stall_p = 1'b0;
        d_p     = '0;
        l_p     = 1'b0;
        acc_cyc = -1;

        @(posedge clk_in); #1;
        start_in         = 1'b1;
        mode_in          = mode;
        pad_words_in     = pad;
        bus.valid_in     = 1'b1;
        bus.data_in      = 8'(words);
        bus.ready_in     = 1'b1;
        @(negedge clk_in);
        check("idle_ready_out", 32'(bus.ready_out), 32'(0));
        check("idle_busy", 32'(busy_out), 32'(0));

        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(posedge clk_in); #1;
            start_in = spur && (bus.last_out || $urandom_range(0, 3) == 0);
            if (start_in) begin
                mode_in      = 1'($urandom);
                pad_words_in = 4'($urandom);
            end
            bus.valid_in = (idx < 4) && (!rand_valid || $urandom_range(0, 1) == 1);
            bus.data_in  = (idx < 4) ? 8'(words >> (8 * idx)) : 8'($urandom);
            case (rdy_kind)
                0:       bus.ready_in = 1'b1;
                1:       bus.ready_in = (cyc % 3 == 0);
                default: bus.ready_in = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk_in);
            if (cyc == 0) check("busy_rise", 32'(busy_out), 32'(1));
            if (stall_p) begin
                check("stall_valid", 32'(bus.valid_out), 32'(1));
                check("stall_data", 32'(bus.data_out), 32'(d_p));
                check("stall_last", 32'(bus.last_out), 32'(l_p));
            end
            if (bus.valid_out && !bus.ready_in)
                check("stall_ready_out", 32'(bus.ready_out), 32'(0));
            if (bus.valid_in && bus.ready_out) begin
                if (idx == 0) begin
                    acc_cyc = cyc;
                    if (mode)
                        check("pre_pad_before_data",
                              32'(int'(got_d.size()) + int'(bus.valid_out && bus.ready_in) >= padc),
                              32'(1));
                end
                idx++;
            end
            if (bus.valid_out && bus.ready_in) begin
                got_d.push_back(bus.data_out);
                got_l.push_back(bus.last_out);
                got_c.push_back(cyc);
                if (bus.last_out) done = 1'b1;
            end
            stall_p = bus.valid_out && !bus.ready_in;
            d_p     = bus.data_out;
            l_p     = bus.last_out;
            if (abort_after > 0 && got_d.size() == abort_after) break;
        end

        if (abort_after == 0) begin
            check("txn_complete", 32'(done), 32'(1));
            @(posedge clk_in); #1;
            start_in     = 1'b0;
            bus.valid_in = 1'b0;
            bus.ready_in = 1'b1;
            @(negedge clk_in);
            check("busy_fall", 32'(busy_out), 32'(0));
            check("valid_after_last", 32'(bus.valid_out), 32'(0));
            check("last_after_last", 32'(bus.last_out), 32'(0));
        end
    endtask

    vec_t vecs[7];

    initial begin
        logic [31:0] w;
        vecs[0] = '{mode: 1'b0, pad: 4'd3,  rdy: 2'd0, len: 4'd7,  exp: 96'h00_00_00_00_00_00_00_00_44_33_22_11};
        vecs[1] = '{mode: 1'b1, pad: 4'd2,  rdy: 2'd0, len: 4'd6,  exp: 96'h00_00_00_00_00_00_44_33_22_11_00_00};
        vecs[2] = '{mode: 1'b0, pad: 4'd0,  rdy: 2'd0, len: 4'd4,  exp: 96'h00_00_00_00_00_00_00_00_44_33_22_11};
        vecs[3] = '{mode: 1'b1, pad: 4'd0,  rdy: 2'd0, len: 4'd4,  exp: 96'h00_00_00_00_00_00_00_00_44_33_22_11};
        vecs[4] = '{mode: 1'b0, pad: 4'd2,  rdy: 2'd1, len: 4'd6,  exp: 96'h00_00_00_00_00_00_00_00_44_33_22_11};
        vecs[5] = '{mode: 1'b0, pad: 4'd15, rdy: 2'd0, len: 4'd12, exp: 96'h00_00_00_00_00_00_00_00_44_33_22_11};
        vecs[6] = '{mode: 1'b1, pad: 4'd15, rdy: 2'd1, len: 4'd12, exp: 96'h44_33_22_11_00_00_00_00_00_00_00_00};

        bus.data_in  = '0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        #1 rst_in = 1'b1;
        #1;
        check("rst_data_out", 32'(bus.data_out), 32'(0));
        check("rst_valid_out", 32'(bus.valid_out), 32'(0));
        check("rst_last_out", 32'(bus.last_out), 32'(0));
        check("rst_busy_out", 32'(busy_out), 32'(0));
        check("rst_ready_out", 32'(bus.ready_out), 32'(0));
        repeat (2) @(posedge clk_in);
        @(negedge clk_in) rst_in = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].mode, vecs[v].pad, int'(vecs[v].rdy), 32'h44332211, 1'b0, 1'b0, 0);
            exp_q.delete();
            for (int i = 0; i < int'(vecs[v].len); i++) exp_q.push_back(8'(vecs[v].exp >> (8 * i)));
            compare($sformatf("vec%0d", v));
            if (vecs[v].rdy == 2'd0 && got_c.size() > 0) begin
                for (int i = 1; i < got_c.size(); i++)
                    check($sformatf("vec%0d_consec%0d", v, i), 32'(got_c[i]), 32'(got_c[0] + i));
                if (!vecs[v].mode || vecs[v].pad == 4'd0)
                    check($sformatf("vec%0d_latency", v), 32'(got_c[0]), 32'(acc_cyc + 1));
            end
        end

        // Abort an APPEND pad-2 transaction after two words, with spurious starts while busy.
        run_txn(1'b0, 4'd2, 0, 32'h44332211, 1'b0, 1'b1, 2);
        check("abort_len", 32'(got_d.size()), 32'(2));
        if (got_d.size() == 2) begin
            check("abort_w0", 32'(got_d[0]), 32'h11);
            check("abort_w1", 32'(got_d[1]), 32'h22);
            check("abort_l1", 32'(got_l[1]), 32'(0));
        end
        #2 rst_in = 1'b1;
        #1;
        check("mid_rst_data_out", 32'(bus.data_out), 32'(0));
        check("mid_rst_valid_out", 32'(bus.valid_out), 32'(0));
        check("mid_rst_last_out", 32'(bus.last_out), 32'(0));
        check("mid_rst_busy_out", 32'(busy_out), 32'(0));
        check("mid_rst_ready_out", 32'(bus.ready_out), 32'(0));
        start_in     = 1'b0;
        bus.valid_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in) rst_in = 1'b0;
        w = 32'hA1B2C3D4;
        run_txn(1'b1, 4'd1, 2, w, 1'b1, 1'b0, 0);
        build_model(1'b1, 4'd1, w);
        compare("post_rst");

        for (int t = 0; t < 30; t++) begin
            logic       m;
            logic [3:0] p;
            m = 1'($urandom);
            p = 4'($urandom_range(0, 15));
            w = $urandom;
            run_txn(m, p, 2, w, 1'b1, 1'b1, 0);
            build_model(m, p, w);
            compare($sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
